mux21_arbiter: RTL and testbench

Two-requester round-robin arbiter that sequences the shared 2:1 mux. It owns the SEL line so that only one requester drives the shared output at a time. Requesters A and B raise REQ, receive a registered one-hot grant, and have their data captured onto the shared registered OUT. Grant tenure is capped under contention so neither side can starve the other.

---
 rtl/mux21_arbiter.sv | 105 ++++++++++
 tb/tb_mux21_arbiter.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/mux21_arbiter.sv
// Two-requester round-robin arbiter driving a shared registered 2:1 mux.
// Grant tenure is capped at MAX_HOLD cycles while the other side is waiting.
module mux21_arbiter #(
  parameter int DATA_W   = 1,
  parameter int MAX_HOLD = 4
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic              REQ_A,
  input  logic              REQ_B,
  input  logic [DATA_W-1:0] A,
  input  logic [DATA_W-1:0] B,
  output logic              GNT_A,
  output logic              GNT_B,
  output logic              SEL,
  output logic [DATA_W-1:0] OUT,
  output logic              VALID
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    OWN_A = 2'd1,
    OWN_B = 2'd2
  } state_t;

  localparam logic [3:0] HOLD_LIMIT = 4'(MAX_HOLD);

  state_t     state_reg, state_next;
  logic [3:0] hold_reg, hold_next;
  logic       last_b_reg, last_b_next;  // 1 when B was the most recent owner

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_reg  <= IDLE;
      hold_reg   <= 4'd0;
      last_b_reg <= 1'b1;
    end else begin
      state_reg  <= state_next;
      hold_reg   <= hold_next;
      last_b_reg <= last_b_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: begin
        if (REQ_A && REQ_B) state_next = last_b_reg ? OWN_A : OWN_B;
        else if (REQ_A)     state_next = OWN_A;
        else if (REQ_B)     state_next = OWN_B;
      end
      OWN_A: begin
        // A release takes priority so the handoff never inserts an idle bubble
        if (!REQ_A)                            state_next = REQ_B ? OWN_B : IDLE;
        else if (REQ_B && hold_reg >= HOLD_LIMIT) state_next = OWN_B;
      end
      OWN_B: begin
        if (!REQ_B)                            state_next = REQ_A ? OWN_A : IDLE;
        else if (REQ_A && hold_reg >= HOLD_LIMIT) state_next = OWN_A;
      end
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    hold_next = hold_reg;
    if (state_next == IDLE)           hold_next = 4'd0;
    else if (state_next != state_reg) hold_next = 4'd1;
    else if (hold_reg < HOLD_LIMIT)   hold_next = hold_reg + 4'd1;
  end

  always_comb begin
    last_b_next = last_b_reg;
    if (state_reg == OWN_A && state_next != OWN_A) last_b_next = 1'b0;
    if (state_reg == OWN_B && state_next != OWN_B) last_b_next = 1'b1;
  end

  // Grants and select decode straight from the state register, so they are
  // glitch-free registered outputs and fall with the asynchronous reset.
  always_comb begin
    GNT_A = (state_reg == OWN_A);
    GNT_B = (state_reg == OWN_B);
    SEL   = (state_reg == OWN_B);
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      OUT   <= '0;
      VALID <= 1'b0;
    end else begin
      case (state_reg)
        OWN_A: begin
          OUT   <= A;
          VALID <= 1'b1;
        end
        OWN_B: begin
          OUT   <= B;
          VALID <= 1'b1;
        end
        default: VALID <= 1'b0;
      endcase
    end
  end

endmodule

// File: tb/tb_mux21_arbiter.sv
// Directed bench for mux21_arbiter: one MAX_HOLD=4 instance and one MAX_HOLD=1
// instance share the same stimulus; each task checks its own scenario.
module tb_mux21_arbiter;
  localparam int W = 4;

  logic         CLK = 1'b0;
  logic         RST_N = 1'b0;
  logic         REQ_A = 1'b0;
  logic         REQ_B = 1'b0;
  logic [W-1:0] A = '0;
  logic [W-1:0] B = '0;

  logic         gnt_a4, gnt_b4, sel4, valid4;
  logic [W-1:0] out4;
  logic         gnt_a1, gnt_b1, sel1, valid1;
  logic [W-1:0] out1;

  int n_cmp = 0;
  int n_err = 0;

  always #5 CLK = ~CLK;

  mux21_arbiter #(.DATA_W(W), .MAX_HOLD(4)) dut4 (
    .CLK(CLK), .RST_N(RST_N), .REQ_A(REQ_A), .REQ_B(REQ_B), .A(A), .B(B),
    .GNT_A(gnt_a4), .GNT_B(gnt_b4), .SEL(sel4), .OUT(out4), .VALID(valid4)
  );

  mux21_arbiter #(.DATA_W(W), .MAX_HOLD(1)) dut1 (
    .CLK(CLK), .RST_N(RST_N), .REQ_A(REQ_A), .REQ_B(REQ_B), .A(A), .B(B),
    .GNT_A(gnt_a1), .GNT_B(gnt_b1), .SEL(sel1), .OUT(out1), .VALID(valid1)
  );

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic do_reset();
    RST_N = 1'b0;
    REQ_A = 1'b0;
    REQ_B = 1'b0;
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    RST_N = 1'b1;
  endtask

  task automatic test_reset();
    RST_N = 1'b0;
    REQ_A = 1'b1;
    REQ_B = 1'b1;
    repeat (3) @(posedge CLK);
    #1;
    n_cmp++; if (gnt_a4 !== 1'b0) begin n_err++; $display("FAIL reset_gnt_a got=%b want=0", gnt_a4); end
    n_cmp++; if (gnt_b4 !== 1'b0) begin n_err++; $display("FAIL reset_gnt_b got=%b want=0", gnt_b4); end
    n_cmp++; if (sel4 !== 1'b0) begin n_err++; $display("FAIL reset_sel got=%b want=0", sel4); end
    n_cmp++; if (out4 !== 4'h0) begin n_err++; $display("FAIL reset_out got=%h want=0", out4); end
    n_cmp++; if (valid4 !== 1'b0) begin n_err++; $display("FAIL reset_valid got=%b want=0", valid4); end
    @(negedge CLK);
    RST_N = 1'b1;
    tick();
    n_cmp++; if (gnt_a4 !== 1'b1 || gnt_b4 !== 1'b0) begin n_err++; $display("FAIL reset_first_grant got=a%b b%b want=a1 b0", gnt_a4, gnt_b4); end
    $display("test_reset done: cmp=%0d err=%0d", n_cmp, n_err);
  endtask

  task automatic test_single();
    do_reset();
    A = 4'h5;
    B = 4'h0;
    REQ_A = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      n_cmp++; if (gnt_a4 !== 1'b1 || gnt_b4 !== 1'b0 || sel4 !== 1'b0) begin n_err++; $display("FAIL single_grant[%0d] got=a%b b%b s%b want=a1 b0 s0", i, gnt_a4, gnt_b4, sel4); end
      if (i == 0) begin
        n_cmp++; if (valid4 !== 1'b0 || out4 !== 4'h0) begin n_err++; $display("FAIL single_first got=v%b o%h want=v0 o0", valid4, out4); end
      end else begin
        n_cmp++; if (valid4 !== 1'b1 || out4 !== 4'h5) begin n_err++; $display("FAIL single_data[%0d] got=v%b o%h want=v1 o5", i, valid4, out4); end
      end
    end
    REQ_A = 1'b0;
    tick();
    n_cmp++; if (gnt_a4 !== 1'b0 || valid4 !== 1'b1 || out4 !== 4'h5) begin n_err++; $display("FAIL single_drop got=g%b v%b o%h want=g0 v1 o5", gnt_a4, valid4, out4); end
    tick();
    n_cmp++; if (valid4 !== 1'b0 || out4 !== 4'h5 || gnt_b4 !== 1'b0) begin n_err++; $display("FAIL single_idle got=v%b o%h gb%b want=v0 o5 gb0", valid4, out4, gnt_b4); end
    $display("test_single done: cmp=%0d err=%0d", n_cmp, n_err);
  endtask

  task automatic test_contention();
    logic         exp_a, prev_a;
    logic [W-1:0] exp_out;
    do_reset();
    A = 4'hA;
    B = 4'hB;
    REQ_A = 1'b1;
    REQ_B = 1'b1;
    prev_a = 1'b1;
    for (int i = 0; i < 12; i++) begin
      tick();
      exp_a = ((i / 4) % 2) == 0;  // AAAABBBBAAAA
      n_cmp++; if (gnt_a4 !== exp_a || gnt_b4 !== !exp_a || sel4 !== !exp_a) begin n_err++; $display("FAIL contend_grant[%0d] got=a%b b%b s%b want=a%b b%b s%b", i, gnt_a4, gnt_b4, sel4, exp_a, !exp_a, !exp_a); end
      if (i > 0) begin
        exp_out = prev_a ? 4'hA : 4'hB;
        n_cmp++; if (valid4 !== 1'b1 || out4 !== exp_out) begin n_err++; $display("FAIL contend_out[%0d] got=v%b o%h want=v1 o%h", i, valid4, out4, exp_out); end
      end
      prev_a = exp_a;
    end
    $display("test_contention done: cmp=%0d err=%0d", n_cmp, n_err);
  endtask

  task automatic test_early_release();
    do_reset();
    A = 4'h3;
    B = 4'h7;
    REQ_B = 1'b1;
    tick();
    n_cmp++; if (gnt_b4 !== 1'b1 || sel4 !== 1'b1 || gnt_a4 !== 1'b0) begin n_err++; $display("FAIL early_own_b got=a%b b%b s%b want=a0 b1 s1", gnt_a4, gnt_b4, sel4); end
    REQ_A = 1'b1;
    tick();
    n_cmp++; if (gnt_b4 !== 1'b1 || gnt_a4 !== 1'b0) begin n_err++; $display("FAIL early_b_cycle2 got=a%b b%b want=a0 b1", gnt_a4, gnt_b4); end
    REQ_B = 1'b0;
    tick();
    n_cmp++; if (gnt_a4 !== 1'b1 || gnt_b4 !== 1'b0 || sel4 !== 1'b0) begin n_err++; $display("FAIL early_handoff got=a%b b%b s%b want=a1 b0 s0", gnt_a4, gnt_b4, sel4); end
    n_cmp++; if (valid4 !== 1'b1 || out4 !== 4'h7) begin n_err++; $display("FAIL early_out_b got=v%b o%h want=v1 o7", valid4, out4); end
    tick();
    n_cmp++; if (valid4 !== 1'b1 || out4 !== 4'h3) begin n_err++; $display("FAIL early_out_a got=v%b o%h want=v1 o3", valid4, out4); end
    $display("test_early_release done: cmp=%0d err=%0d", n_cmp, n_err);
  endtask

  task automatic test_back_to_back();
    do_reset();
    A = 4'h1;
    B = 4'h2;
    REQ_A = 1'b1;
    tick();
    tick();
    REQ_A = 1'b0;
    REQ_B = 1'b1;
    tick();
    n_cmp++; if (gnt_b4 !== 1'b1 || gnt_a4 !== 1'b0 || sel4 !== 1'b1) begin n_err++; $display("FAIL swap_same_edge got=a%b b%b s%b want=a0 b1 s1", gnt_a4, gnt_b4, sel4); end
    n_cmp++; if (valid4 !== 1'b1 || out4 !== 4'h1) begin n_err++; $display("FAIL swap_out got=v%b o%h want=v1 o1", valid4, out4); end
    $display("test_back_to_back done: cmp=%0d err=%0d", n_cmp, n_err);
  endtask

  task automatic test_reset_mid();
    do_reset();
    A = 4'h4;
    B = 4'h9;
    REQ_A = 1'b1;
    tick();
    REQ_A = 1'b0;
    REQ_B = 1'b1;
    tick();
    tick();
    n_cmp++; if (gnt_b4 !== 1'b1 || valid4 !== 1'b1) begin n_err++; $display("FAIL mid_pre got=b%b v%b want=b1 v1", gnt_b4, valid4); end
    RST_N = 1'b0;
    #2;
    n_cmp++; if (gnt_b4 !== 1'b0 || sel4 !== 1'b0 || valid4 !== 1'b0 || out4 !== 4'h0) begin n_err++; $display("FAIL mid_async got=b%b s%b v%b o%h want=b0 s0 v0 o0", gnt_b4, sel4, valid4, out4); end
    REQ_A = 1'b1;
    REQ_B = 1'b1;
    #2;
    RST_N = 1'b1;
    tick();
    n_cmp++; if (gnt_a4 !== 1'b1 || gnt_b4 !== 1'b0) begin n_err++; $display("FAIL mid_restart got=a%b b%b want=a1 b0", gnt_a4, gnt_b4); end
    $display("test_reset_mid done: cmp=%0d err=%0d", n_cmp, n_err);
  endtask

  task automatic test_max_hold_one();
    logic         exp_a;
    logic [W-1:0] exp_out;
    do_reset();
    A = 4'hC;
    B = 4'h6;
    REQ_A = 1'b1;
    REQ_B = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick();
      exp_a = (i % 2) == 0;
      n_cmp++; if (gnt_a1 !== exp_a || gnt_b1 !== !exp_a || sel1 !== !exp_a) begin n_err++; $display("FAIL hold1_grant[%0d] got=a%b b%b s%b want=a%b b%b s%b", i, gnt_a1, gnt_b1, sel1, exp_a, !exp_a, !exp_a); end
      if (i > 0) begin
        exp_out = exp_a ? 4'h6 : 4'hC;
        n_cmp++; if (valid1 !== 1'b1 || out1 !== exp_out) begin n_err++; $display("FAIL hold1_out[%0d] got=v%b o%h want=v1 o%h", i, valid1, out1, exp_out); end
      end
    end
    $display("test_max_hold_one done: cmp=%0d err=%0d", n_cmp, n_err);
  endtask

  initial begin
    test_reset();
    test_single();
    test_contention();
    test_early_release();
    test_back_to_back();
    test_reset_mid();
    test_max_hold_one();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
